ram_1r1w_fwd_init: RTL
======================

Name: ram_1r1w_fwd_init

Overview:
- Next-generation simple dual-port RAM: one write port, one read port, configurable read latency 1-3.
- Adds write-to-read forwarding, a hardware clear-on-reset sequencer, and a read-valid output.
- Adds per-segment parity with error address capture, sticky flag, counter and injection.
- Used for FIM descriptor/tag stores that need deterministic contents after reset and coherent read-after-write.

Parameters:
DEPTH, 4, address width in bits; entries = 2**DEPTH
WIDTH, 32, data width in bits
READ_LATENCY, 2, cycles from accepted re to dout_valid; legal 1..3
BYPASS, 1, 1 = forward in-flight writes to colliding reads
INCLUDE_PARITY, 1, 1 = store and check parity
BITS_PER_PARITY, 32, data bits per parity bit; PW = ceil(WIDTH/BITS_PER_PARITY)
INIT_ON_RESET, 1, 1 = write INIT_VALUE to every entry after reset
INIT_VALUE, '0, WIDTH-bit clear value

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
we  in  1  write enable
waddr  in  DEPTH  write address
din  in  WIDTH  write data
inj_perr  in  1  with we: invert stored parity bit 0 for this write
re  in  1  read enable
raddr  in  DEPTH  read address
dout  out  WIDTH  read data
dout_valid  out  1  dout carries data for an accepted read
perr  out  1  parity mismatch on current dout_valid beat
perr_addr  out  DEPTH  raddr of first error since last clear
perr_sticky  out  1  any parity error since last clear
perr_cnt  out  8  saturating parity error count
err_clr  in  1  clears perr_sticky, perr_cnt, perr_addr
init_done  out  1  RAM ready; accesses accepted only when high
acc_drop  out  1  sticky: we or re asserted while init_done=0

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, FSM to INIT, init address counter 0; RAM contents not reset.
- FSM INIT: one write per cycle of INIT_VALUE with correct parity, address 0..2**DEPTH-1.
  - Advances to READY after the last address; init_done=1 from the cycle after the last init write.
  - INIT_ON_RESET=0: INIT skipped; init_done=1 the first cycle after rst_n deasserts.
  - rst_n low mid-INIT restarts at address 0.
- READY: we/re accepted every cycle, no backpressure.
  - While init_done=0, we/re are ignored and acc_drop is set; acc_drop clears only on reset.
- Read accepted at cycle t: dout and dout_valid=1 at t+READ_LATENCY.
  - dout holds its last value when dout_valid=0.
  - Back-to-back reads give back-to-back valid beats.
- Read ordering (BYPASS=1): a read accepted at t returns the data of the latest write accepted at or before t to that address, including a same-cycle write. Implemented by comparing raddr against the write pipeline for READ_LATENCY+1 cycles; the youngest match wins.
- Read ordering (BYPASS=0): same-cycle collision returns old data for READ_LATENCY>=2 and undefined data for READ_LATENCY=1; the bench must not check that case.
- Parity:
  - Even parity per segment; the last segment covers the remaining bits.
  - Checked on every dout_valid beat; perr is 1 on that same beat on mismatch.
  - Forwarded data uses stored-path parity, so an injected error is also seen via bypass.
- Error capture:
  - perr_addr loads only when perr_sticky is 0.
  - perr_cnt saturates at 255.
  - err_clr and a new perr in the same cycle: error wins (sticky=1, cnt=1, addr loaded).
- INCLUDE_PARITY=0: perr, perr_sticky, perr_cnt and perr_addr tied 0; inj_perr ignored.

Decomposition:
- Package ram_1r1w_fwd_pkg holds:
  - state enum {INIT, READY};
  - function parity_width(WIDTH, BITS_PER_PARITY);
  - function calc_par(data) returning PW bits.
- Storage is a gram_sdp instance with width WIDTH+PW, used in its registered-output mode; extra latency stages are added in this block.
- One sub-module, ram_1r1w_fwd_match: the write-history shift register plus the youngest-match comparator.

Test Plan:
- Init: DEPTH=4, INIT_VALUE=32'hA5A5A5A5; release reset -> init_done rises exactly 16 cycles later; reads of addresses 0..15 return A5A5A5A5 with perr=0.
- Latency: READ_LATENCY=1,2,3; write 0x11 to addr 3, later re addr 3 at cycle t -> dout=0x11 and dout_valid=1 at t+L only.
- Forwarding: BYPASS=1, L=3; same-cycle we/re addr 5 with din=0xBEEF -> 0xBEEF; writes 1,2,3 to addr 5 in consecutive cycles, each with a read -> 1,2,3.
- Parity injection: write addr 7 with inj_perr=1, then read it twice -> perr=1 on both beats, perr_cnt=2, perr_addr=7; err_clr concurrent with a third erroring read -> perr_cnt=1, perr_sticky=1.
- Access during init: re and we asserted at cycle 2 of INIT -> no dout_valid, memory unchanged, acc_drop=1 until reset.
- Reset mid-init: rst_n low at init address 9 -> init restarts at 0; init_done rises 16 cycles after release.

Source files
------------

// File: rtl/ram_1r1w_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_1r1w_fwd_pkg
// Description : Shared types and parity helpers for ram_1r1w_fwd_init.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_1r1w_fwd_pkg;

    // Sequencer states: clear every entry first, then serve accesses
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Widest data word the parity helper handles
    localparam int MAX_WIDTH = 256;
    localparam int MAX_PW    = 256;

    // Number of parity bits; the last segment takes the leftover bits
    function automatic int parity_width(input int width, input int bits_per_parity);
        return (width + bits_per_parity - 1) / bits_per_parity;
    endfunction

    // Even parity per segment; only the low parity_width() bits are meaningful
    function automatic logic [MAX_PW-1:0] calc_par(
        input logic [MAX_WIDTH-1:0] data,
        input int                   width,
        input int                   bits_per_parity
    );
        logic [MAX_PW-1:0] par;
        logic [7:0]        seg;
        logic [7:0]        idx;
        int                cnt;
        par = '0;
        seg = '0;
        cnt = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            idx = i[7:0];
            if (i < width) begin
                par[seg] = par[seg] ^ data[idx];
                cnt      = cnt + 1;
                if (cnt == bits_per_parity) begin
                    cnt = 0;
                    seg = seg + 8'd1;
                end
            end
        end
        return par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : gram_sdp
// Description : Simple dual-port RAM, registered output, read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module gram_sdp #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value between reads
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Output register update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ram_1r1w_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : ram_1r1w_fwd_match
// Description : Recent-write history and youngest-match forwarding compare.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1r1w_fwd_match #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 36,
    parameter int HIST   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic              hv_q [HIST];
    logic              hv_d [HIST];
    logic [ADDR_W-1:0] ha_q [HIST];
    logic [ADDR_W-1:0] ha_d [HIST];
    logic [DATA_W-1:0] hd_q [HIST];
    logic [DATA_W-1:0] hd_d [HIST];

    // Entry 0 takes the current write, older entries age by one slot
    always_comb begin
        hv_d[0] = wr_en;
        ha_d[0] = wr_addr;
        hd_d[0] = wr_data;
        for (int i = 1; i < HIST; i++) begin
            hv_d[i] = hv_q[i-1];
            ha_d[i] = ha_q[i-1];
            hd_d[i] = hd_q[i-1];
        end
    end

    // History registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST; i++) begin
                hv_q[i] <= 1'b0;
                ha_q[i] <= '0;
                hd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < HIST; i++) begin
                hv_q[i] <= hv_d[i];
                ha_q[i] <= ha_d[i];
                hd_q[i] <= hd_d[i];
            end
        end
    end

    // Scan oldest to youngest so the youngest match overrides; the same-cycle write is youngest
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = HIST - 1; i >= 0; i--) begin
            if (hv_q[i] && (ha_q[i] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = hd_q[i];
            end
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            hit      = 1'b1;
            hit_data = wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_1r1w_fwd_init.sv
`default_nettype none
// ============================================================================
// Module      : ram_1r1w_fwd_init
// Description : 1R1W RAM with clear-on-reset, write forwarding and parity.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1r1w_fwd_init
    import ram_1r1w_fwd_pkg::*;
#(
    parameter int               DEPTH           = 4,
    parameter int               WIDTH           = 32,
    parameter int               READ_LATENCY    = 2,
    parameter int               BYPASS          = 1,
    parameter int               INCLUDE_PARITY  = 1,
    parameter int               BITS_PER_PARITY = 32,
    parameter int               INIT_ON_RESET   = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] din,
    input  logic             inj_perr,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             perr,
    output logic [DEPTH-1:0] perr_addr,
    output logic             perr_sticky,
    output logic [7:0]       perr_cnt,
    input  logic             err_clr,
    output logic             init_done,
    output logic             acc_drop
);

    localparam int               PW          = parity_width(WIDTH, BITS_PER_PARITY);
    localparam int               SW          = WIDTH + PW;
    localparam logic [DEPTH-1:0] C_LAST_ADDR = '1;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] init_addr_q, init_addr_d;
    logic             init_done_q, init_done_d;
    logic             acc_drop_q, acc_drop_d;

    logic              w_init_we, w_usr_we, w_usr_re, w_wr_en;
    logic [DEPTH-1:0]  w_wr_addr;
    logic [WIDTH-1:0]  w_wr_data;
    logic [MAX_WIDTH-1:0] w_wr_ext, w_chk_ext;
    logic [MAX_PW-1:0] w_wr_par_full, w_chk_par_full;
    logic [PW-1:0]     w_wr_par, w_chk_par;
    logic [SW-1:0]     w_wr_word, w_ram_rdata, w_hit_data, w_out_word;
    logic              w_hit, w_perr, w_unused_par;

    logic             rd_v_q, rd_v_d, rd_fwd_q, rd_fwd_d;
    logic [SW-1:0]    rd_fwd_data_q, rd_fwd_data_d;
    logic [DEPTH-1:0] rd_addr_q, rd_addr_d;

    logic             perr_sticky_q, perr_sticky_d;
    logic [7:0]       perr_cnt_q, perr_cnt_d;
    logic [DEPTH-1:0] perr_addr_q, perr_addr_d;

    // Clear sequencer: one INIT_VALUE write per cycle, then READY forever
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                if (INIT_ON_RESET == 0) begin
                    state_d     = READY;
                    init_done_d = 1'b1;
                end else begin
                    init_addr_d = init_addr_q + DEPTH'(1);
                    if (init_addr_q == C_LAST_ADDR) begin
                        state_d     = READY;
                        init_done_d = 1'b1;
                    end
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // User accesses only count once the clear is done; early attempts are flagged
    always_comb begin
        w_init_we  = (state_q == INIT) && (INIT_ON_RESET != 0);
        w_usr_we   = we & init_done_q;
        w_usr_re   = re & init_done_q;
        acc_drop_d = acc_drop_q | (~init_done_q & (we | re));
    end

    // Write port: sequencer or user data, stored together with its parity
    always_comb begin
        w_wr_en       = w_init_we | w_usr_we;
        w_wr_addr     = w_init_we ? init_addr_q : waddr;
        w_wr_data     = w_init_we ? INIT_VALUE : din;
        w_wr_ext      = '0;
        w_wr_ext[WIDTH-1:0] = w_wr_data;
        w_wr_par_full = calc_par(w_wr_ext, WIDTH, BITS_PER_PARITY);
        w_wr_par      = w_wr_par_full[PW-1:0];
        if (INCLUDE_PARITY == 0) begin
            w_wr_par = '0;
        end else if (w_usr_we && inj_perr) begin
            w_wr_par[0] = ~w_wr_par[0];
        end
        w_wr_word = {w_wr_par, w_wr_data};
    end

    gram_sdp #(
        .ADDR_W (DEPTH),
        .DATA_W (SW)
    ) u_gram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_en),
        .waddr (w_wr_addr),
        .wdata (w_wr_word),
        .re    (w_usr_re),
        .raddr (raddr),
        .rdata (w_ram_rdata)
    );

    ram_1r1w_fwd_match #(
        .ADDR_W (DEPTH),
        .DATA_W (SW),
        .HIST   (READ_LATENCY)
    ) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_word),
        .rd_addr  (raddr),
        .hit      (w_hit),
        .hit_data (w_hit_data)
    );

    // First read stage: decide forwarding at accept time, hold between reads
    always_comb begin
        rd_v_d        = w_usr_re;
        rd_fwd_d      = rd_fwd_q;
        rd_fwd_data_d = rd_fwd_data_q;
        rd_addr_d     = rd_addr_q;
        if (w_usr_re) begin
            rd_fwd_d      = (BYPASS != 0) ? w_hit : 1'b0;
            rd_fwd_data_d = w_hit_data;
            rd_addr_d     = raddr;
        end
    end

    // Sequencer, access flag and first read stage registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= INIT;
            init_addr_q   <= '0;
            init_done_q   <= 1'b0;
            acc_drop_q    <= 1'b0;
            rd_v_q        <= 1'b0;
            rd_fwd_q      <= 1'b0;
            rd_fwd_data_q <= '0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            init_addr_q   <= init_addr_d;
            init_done_q   <= init_done_d;
            acc_drop_q    <= acc_drop_d;
            rd_v_q        <= rd_v_d;
            rd_fwd_q      <= rd_fwd_d;
            rd_fwd_data_q <= rd_fwd_data_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    logic [SW-1:0]    w_word [READ_LATENCY];
    logic             w_vld  [READ_LATENCY];
    logic [DEPTH-1:0] w_addr [READ_LATENCY];

    assign w_word[0] = rd_fwd_q ? rd_fwd_data_q : w_ram_rdata;
    assign w_vld[0]  = rd_v_q;
    assign w_addr[0] = rd_addr_q;

    for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
        logic [SW-1:0]    word_q, word_d;
        logic             vld_q, vld_d;
        logic [DEPTH-1:0] addr_q, addr_d;

        // Extra latency stage; word only advances with a valid beat
        always_comb begin
            vld_d  = w_vld[k-1];
            word_d = word_q;
            addr_d = addr_q;
            if (w_vld[k-1]) begin
                word_d = w_word[k-1];
                addr_d = w_addr[k-1];
            end
        end

        // Stage registers
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                word_q <= '0;
                addr_q <= '0;
            end else begin
                vld_q  <= vld_d;
                word_q <= word_d;
                addr_q <= addr_d;
            end
        end

        assign w_word[k] = word_q;
        assign w_vld[k]  = vld_q;
        assign w_addr[k] = addr_q;
    end

    // Output check: recompute parity over the data and compare with the stored bits
    always_comb begin
        w_out_word = w_word[READ_LATENCY-1];
        w_chk_ext  = '0;
        w_chk_ext[WIDTH-1:0] = w_out_word[WIDTH-1:0];
        w_chk_par_full = calc_par(w_chk_ext, WIDTH, BITS_PER_PARITY);
        w_chk_par  = w_chk_par_full[PW-1:0];
        w_perr     = (INCLUDE_PARITY != 0) && w_vld[READ_LATENCY-1] &&
                     (w_chk_par != w_out_word[SW-1:WIDTH]);
    end

    assign w_unused_par = ^w_wr_par_full[MAX_PW-1:PW] ^ ^w_chk_par_full[MAX_PW-1:PW];

    // Error capture: a new error takes priority over a same-cycle clear
    always_comb begin
        perr_sticky_d = perr_sticky_q;
        perr_cnt_d    = perr_cnt_q;
        perr_addr_d   = perr_addr_q;
        if (w_perr) begin
            perr_sticky_d = 1'b1;
            if (err_clr) begin
                perr_cnt_d = 8'd1;
            end else if (perr_cnt_q != 8'hFF) begin
                perr_cnt_d = perr_cnt_q + 8'd1;
            end
            if (!perr_sticky_q || err_clr) begin
                perr_addr_d = w_addr[READ_LATENCY-1];
            end
        end else if (err_clr) begin
            perr_sticky_d = 1'b0;
            perr_cnt_d    = 8'd0;
            perr_addr_d   = '0;
        end
    end

    // Error capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_sticky_q <= 1'b0;
            perr_cnt_q    <= 8'd0;
            perr_addr_q   <= '0;
        end else begin
            perr_sticky_q <= perr_sticky_d;
            perr_cnt_q    <= perr_cnt_d;
            perr_addr_q   <= perr_addr_d;
        end
    end

    assign dout        = w_out_word[WIDTH-1:0];
    assign dout_valid  = w_vld[READ_LATENCY-1];
    assign perr        = w_perr;
    assign perr_addr   = perr_addr_q;
    assign perr_sticky = perr_sticky_q;
    assign perr_cnt    = perr_cnt_q;
    assign init_done   = init_done_q;
    assign acc_drop    = acc_drop_q;

endmodule
`default_nettype wire
